// File: rtl/tdm_demux8.sv
// rtl/tdm_demux8.sv - 8-channel TDM serial-to-parallel demultiplexer with frame-sync lock
module tdm_demux8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       frame_sync,
  output logic [7:0] out,
  output logic       out_valid,
  output logic [2:0] ch,
  output logic       lock,
  output logic       sync_err
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [6:0] shadow;

  assign ch   = cnt;
  assign lock = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      cnt       <= 3'd0;
      shadow    <= 7'd0;
      out       <= 8'h00;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              shadow[0] <= din;
              cnt       <= 3'd1;
              state     <= LOCKED;
            end
          end
          LOCKED: begin
            if (frame_sync) begin
              // A sync anywhere but channel 0 restarts the frame at this bit
              if (cnt != 3'd0) sync_err <= 1'b1;
              shadow[0] <= din;
              cnt       <= 3'd1;
            end else if (cnt == 3'd0) begin
              sync_err <= 1'b1;
              state    <= HUNT;
            end else if (cnt == 3'd7) begin
              out       <= {din, shadow};
              out_valid <= 1'b1;
              cnt       <= 3'd0;
            end else begin
              shadow[cnt] <= din;
              cnt         <= cnt + 3'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux8.sv
// tb/tb_tdm_demux8.sv - directed vector bench for tdm_demux8
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst, din, din_valid, frame_sync;
  logic [7:0] out;
  logic       out_valid, lock, sync_err;
  logic [2:0] ch;

  int n_tests = 0;
  int n_fail  = 0;

  tdm_demux8 dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_sync(frame_sync),
    .out(out), .out_valid(out_valid), .ch(ch), .lock(lock), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, dv, fs, d;
    logic [7:0] eo;
    logic       eov;
    logic [2:0] ech;
    logic       elk, eerr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, dv, fs, d, input logic [7:0] eo, input logic eov,
                     input logic [2:0] ech, input logic elk, eerr);
    vec_t v;
    v.r = r; v.dv = dv; v.fs = fs; v.d = d;
    v.eo = eo; v.eov = eov; v.ech = ech; v.elk = elk; v.eerr = eerr;
    vq.push_back(v);
  endtask

  // One locked, gap-free frame: channel k bit is val[k], out changes only after channel 7
  task automatic frame_rows(input logic [7:0] val, input logic [7:0] prev);
    for (int k = 0; k < 8; k++)
      add(1'b0, 1'b1, k == 0, val[k], (k == 7) ? val : prev, k == 7, 3'(k + 1), 1'b1, 1'b0);
  endtask

  task automatic step(input logic r, dv, fs, d);
    rst = r; din_valid = dv; frame_sync = fs; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [7:0] eo, input logic eov,
                            input logic [2:0] ech, input logic elk, eerr);
    chk({tag, " out"}, out, eo);
    chk({tag, " out_valid"}, {7'd0, out_valid}, {7'd0, eov});
    chk({tag, " ch"}, {5'd0, ch}, {5'd0, ech});
    chk({tag, " lock"}, {7'd0, lock}, {7'd0, elk});
    chk({tag, " sync_err"}, {7'd0, sync_err}, {7'd0, eerr});
  endtask

  task automatic send_frame(input string tag, input logic [7:0] val, input logic [7:0] prev);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, k == 0, val[k]);
      expect_all($sformatf("%s ch%0d", tag, k), (k == 7) ? val : prev, k == 7,
                 3'(k + 1), 1'b1, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;

    // Reset with random inputs, then single frame 4D
    for (int i = 0; i < 2; i++)
      add(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    frame_rows(8'h4D, 8'h00);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'h4D, 1'b0, 3'd0, 1'b1, 1'b0);
    // Same frame with a 3-cycle gap after channel 3
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'h4D, 1'b0, 3'd1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h4D, 1'b0, 3'd2, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 8'h4D, 1'b0, 3'd3, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 8'h4D, 1'b0, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'h4D, 1'b0, 3'd4, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h4D, 1'b0, 3'd5, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h4D, 1'b0, 3'd6, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 8'h4D, 1'b0, 3'd7, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h4D, 1'b1, 3'd0, 1'b1, 1'b0);
    frame_rows(8'hA5, 8'h4D);

    foreach (vq[i]) begin
      step(vq[i].r, vq[i].dv, vq[i].fs, vq[i].d);
      expect_all($sformatf("vec%0d", i), vq[i].eo, vq[i].eov, vq[i].ech, vq[i].elk, vq[i].eerr);
    end

    // Early sync on channel 4, new frame 3C starts on that bit
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, k == 0, 1'b1);
      expect_all($sformatf("early pre ch%0d", k), 8'hA5, 1'b0, 3'(k + 1), 1'b1, 1'b0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    expect_all("early sync", 8'hA5, 1'b0, 3'd1, 1'b1, 1'b1);
    for (int k = 1; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'(8'h3C >> k));
      expect_all($sformatf("early post ch%0d", k), (k == 7) ? 8'h3C : 8'hA5, k == 7,
                 3'(k + 1), 1'b1, 1'b0);
    end

    // Missing sync drops lock; unsynced bits are ignored until the next frame_sync
    step(1'b0, 1'b1, 1'b0, 1'b1);
    expect_all("missing sync", 8'h3C, 1'b0, 3'd0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'(k & 1));
      expect_all($sformatf("hunt %0d", k), 8'h3C, 1'b0, 3'd0, 1'b0, 1'b0);
    end
    send_frame("relock", 8'h5A, 8'h3C);

    // Reset after channel 5 of FF; rst wins over a concurrent valid sync
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, k == 0, 1'b1);
      expect_all($sformatf("ff ch%0d", k), 8'h5A, 1'b0, 3'(k + 1), 1'b1, 1'b0);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1);
    expect_all("mid reset", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    send_frame("after reset", 8'h81, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_all("final hold", 8'h81, 1'b0, 3'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux8.md
# tdm_demux8

Serial-to-parallel time-division demultiplexer: the receive end of our 8:1 channel-select mux path. An upstream 8:1 mux serialises channels 0..7 onto one line, one channel per valid cycle, with a frame-sync marker on channel 0. This block recovers the channel index, steers each bit into its lane, and presents a complete registered 8-lane word with a one-cycle valid strobe. It also reports framing lock and sync errors.

## Interface
- Parameters: none. Channel count is fixed at 8; channel index width is fixed at 3.
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, synchronous, active-high
- din  input  1  serial TDM data; one channel bit per valid cycle
- din_valid  input  1  din and frame_sync are sampled only when high
- frame_sync  input  1  marks the current din bit as channel 0; meaningful only with din_valid
- out  output  8  last complete frame; out[k] = channel k bit; registered
- out_valid  output  1  one-cycle pulse when out is updated
- ch  output  3  channel index expected for the next valid bit
- lock  output  1  high while in state LOCKED
- sync_err  output  1  one-cycle pulse on a framing violation

## Operation
- The block has two states: HUNT and LOCKED. It holds a 7-bit shadow register for channels 0..6 and a 3-bit channel counter, cnt, which drives ch.
- Cycles with din_valid low change nothing: state, cnt, shadow and out hold, and out_valid and sync_err are 0.
- **HUNT:**
  - Valid bits without frame_sync are discarded.
  - On din_valid & frame_sync: shadow[0] <= din, cnt <= 1, go to LOCKED.
- **LOCKED, din_valid high:**
  - **frame_sync high with cnt != 0 (early sync):**
    - sync_err pulses and the partial frame is discarded.
    - The bit is taken as channel 0: shadow[0] <= din, cnt <= 1. Stay LOCKED.
    - out and out_valid are unaffected.
  - **frame_sync low with cnt == 0 (missing sync):**
    - sync_err pulses, the bit is discarded, cnt <= 0, go to HUNT.
  - **frame_sync high with cnt == 0:**
    - shadow[0] <= din, cnt <= 1.
  - **frame_sync low with 1 <= cnt <= 6:**
    - shadow[cnt] <= din, cnt <= cnt + 1.
  - **frame_sync low with cnt == 7 (frame complete):**
    - out <= {din, shadow[6:0]} and out_valid pulses.
    - cnt wraps to 0. Stay LOCKED.
- Stale shadow bits from a discarded frame are never exposed, because every frame rewrites all of channels 0..6 before completing.
- The counter is modulo 8. No other arithmetic is performed.
- **Reset:**
  - State HUNT; cnt = 0; shadow = 0.
  - Outputs: out = 8'h00, out_valid = 0, ch = 0, lock = 0, sync_err = 0.
  - Reset mid-frame discards the partial frame. out returns to 8'h00, not to the last frame.

## Timing
- Each valid bit is sampled on the rising edge of clk.
- Latency: out and out_valid are registered and change on the same edge that samples the channel-7 bit. They are visible in the cycle after the channel-7 bit is presented.
- out_valid is high for exactly one cycle per completed frame. out holds its value until the next completed frame or reset.
- Back-to-back frames with din_valid continuously high give one out_valid every 8 cycles.
- lock rises on the edge that samples the first frame_sync in HUNT. It falls on the edge that detects a missing sync.
- sync_err is registered. It is high in the cycle after the offending bit is presented, for exactly one cycle.
- There is no backpressure: the downstream consumer must capture out on out_valid.
- rst has priority over all other inputs in the same cycle.

## Test plan
- **Reset values:** hold rst high for 2 cycles with random din, din_valid and frame_sync.
  - Required: out = 00, out_valid = 0, lock = 0, ch = 0, sync_err = 0.
- **Single frame:** send channels 0..7 = 1,0,1,1,0,0,1,0 with frame_sync on channel 0 and din_valid high continuously.
  - Required: lock = 1 from the 2nd cycle.
  - Required: out = 8'h4D, with a one-cycle out_valid in the cycle after channel 7.
- **Gaps and back-to-back frames:**
  - Send the same frame with din_valid low for 3 cycles between channels 3 and 4.
    - Required: out = 8'h4D arrives 3 cycles later than in the single-frame case; ch holds 4 during the gap.
  - Follow immediately with frame 8'hA5.
    - Required: out_valid pulses exactly 8 valid cycles later, with out = 8'hA5.
- **Early sync:** while LOCKED, assert frame_sync on channel 4, then send a full frame 8'h3C from that bit.
  - Required: one sync_err pulse, lock stays 1, no out_valid for the aborted frame.
  - Required: out = 8'h3C when the new frame completes.
- **Missing sync:** while LOCKED, present the channel-0 bit with frame_sync low.
  - Required: sync_err pulses and lock = 0.
  - Required: bits without frame_sync produce no out_valid.
  - Required: relock only on the next frame_sync.
- **Reset mid-frame:** assert rst for 1 cycle after channel 5 of frame 8'hFF, then send frame 8'h81.
  - Required: out = 00 after the reset; next out_valid gives out = 8'h81; 8'hFF never appears.
